// File: rtl/arm_pkg.sv
// Shared ARM7 exception-entry types: processor modes, exception codes,
// register-bank write targets, vector/LR offsets and the entry CPSR builder.
package arm_pkg;

  typedef enum logic [4:0] {
    MODE_USR = 5'b10000,
    MODE_FIQ = 5'b10001,
    MODE_IRQ = 5'b10010,
    MODE_SVC = 5'b10011,
    MODE_ABT = 5'b10111,
    MODE_UND = 5'b11011
  } mode_t;

  typedef enum logic [2:0] {
    EXC_NONE  = 3'd0,
    EXC_DABT  = 3'd1,
    EXC_FIQ   = 3'd2,
    EXC_IRQ   = 3'd3,
    EXC_PABT  = 3'd4,
    EXC_UNDEF = 3'd5,
    EXC_SWI   = 3'd6
  } exc_t;

  typedef enum logic [1:0] {
    SEL_SPSR = 2'd0,
    SEL_R14  = 2'd1,
    SEL_CPSR = 2'd2,
    SEL_PC   = 2'd3
  } wr_sel_t;

  localparam logic [31:0] VEC_DABT  = 32'h0000_0010;
  localparam logic [31:0] VEC_FIQ   = 32'h0000_001C;
  localparam logic [31:0] VEC_IRQ   = 32'h0000_0018;
  localparam logic [31:0] VEC_PABT  = 32'h0000_000C;
  localparam logic [31:0] VEC_UNDEF = 32'h0000_0004;
  localparam logic [31:0] VEC_SWI   = 32'h0000_0008;

  localparam logic [31:0] LR_OFF_DABT = 32'd8;
  localparam logic [31:0] LR_OFF_STD  = 32'd4;

  // Bit positions inside the sticky pending vector.
  localparam int PEND_DABT  = 0;
  localparam int PEND_PABT  = 1;
  localparam int PEND_UNDEF = 2;
  localparam int PEND_SWI   = 3;

  // Entry CPSR: I always set, F set only for FIQ, Thumb cleared, new mode.
  function automatic logic [31:0] entry_cpsr(input logic [23:0] upper,
                                             input logic        f_bit,
                                             input logic        set_f,
                                             input logic [4:0]  mode);
    return {upper, 1'b1, f_bit | set_f, 1'b0, mode};
  endfunction

endpackage

// File: rtl/exception_prio.sv
// Combinational exception arbiter: applies FIQ/IRQ masking and picks the
// highest-priority source together with its mode, vector and LR offset.
module exception_prio
  import arm_pkg::*;
(
  input  logic [3:0]  i_pend,
  input  logic        i_fiq_req,
  input  logic        i_irq_req,
  input  logic        i_cpsr_i,
  input  logic        i_cpsr_f,
  output logic        o_valid,
  output exc_t        o_exc,
  output mode_t       o_mode,
  output logic [31:0] o_vec_off,
  output logic [31:0] o_lr_off,
  output logic        o_set_f
);

  logic w_fiq_ok;
  logic w_irq_ok;

  assign w_fiq_ok = i_fiq_req & ~i_cpsr_f;
  assign w_irq_ok = i_irq_req & ~i_cpsr_i;

  always_comb begin
    o_valid   = 1'b1;
    o_exc     = EXC_NONE;
    o_mode    = MODE_USR;
    o_vec_off = 32'h0;
    o_lr_off  = LR_OFF_STD;
    o_set_f   = 1'b0;
    if (i_pend[PEND_DABT]) begin
      o_exc     = EXC_DABT;
      o_mode    = MODE_ABT;
      o_vec_off = VEC_DABT;
      o_lr_off  = LR_OFF_DABT;
    end else if (w_fiq_ok) begin
      o_exc     = EXC_FIQ;
      o_mode    = MODE_FIQ;
      o_vec_off = VEC_FIQ;
      o_set_f   = 1'b1;
    end else if (w_irq_ok) begin
      o_exc     = EXC_IRQ;
      o_mode    = MODE_IRQ;
      o_vec_off = VEC_IRQ;
    end else if (i_pend[PEND_PABT]) begin
      o_exc     = EXC_PABT;
      o_mode    = MODE_ABT;
      o_vec_off = VEC_PABT;
    end else if (i_pend[PEND_UNDEF]) begin
      o_exc     = EXC_UNDEF;
      o_mode    = MODE_UND;
      o_vec_off = VEC_UNDEF;
    end else if (i_pend[PEND_SWI]) begin
      o_exc     = EXC_SWI;
      o_mode    = MODE_SVC;
      o_vec_off = VEC_SWI;
    end else begin
      o_valid   = 1'b0;
    end
  end

endmodule

// File: rtl/exception_sequencer.sv
// ARM7 exception entry sequencer: latches sources, arbitrates at an instruction
// boundary, then writes SPSR, R14, CPSR and PC through the register bank port.
module exception_sequencer
  import arm_pkg::*;
#(
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_boundary,
  input  logic [31:0] cur_addr,
  input  logic [31:0] cpsr_in,
  input  logic        fiq_req,
  input  logic        irq_req,
  input  logic        dabt_pulse,
  input  logic        pabt_pulse,
  input  logic        undef_pulse,
  input  logic        swi_pulse,
  output logic        wr_en,
  output logic [1:0]  wr_sel,
  output logic [4:0]  wr_mode,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        flush,
  output logic [2:0]  exc_taken
);

  typedef enum logic [2:0] {
    IDLE,
    SAVE_SPSR,
    WRITE_LR,
    WRITE_CPSR,
    WRITE_PC
  } state_t;

  state_t      r_state;
  logic        r_wr_en;
  wr_sel_t     r_wr_sel;
  logic [4:0]  r_wr_mode;
  logic [31:0] r_wr_data;
  logic        r_busy;
  logic        r_flush;
  logic [2:0]  r_exc_taken;
  logic [4:0]  r_new_mode;
  logic [31:0] r_lr;
  logic [31:0] r_new_cpsr;
  logic [31:0] r_pc;
  logic [2:0]  r_code;
  logic [3:0]  r_pend;

  logic [3:0]  w_pulses;
  logic [3:0]  w_pend;
  logic        w_valid;
  exc_t        w_exc;
  mode_t       w_mode;
  logic [31:0] w_vec_off;
  logic [31:0] w_lr_off;
  logic        w_set_f;
  logic        w_unused_cpsr;

  assign w_pulses      = {swi_pulse, undef_pulse, pabt_pulse, dabt_pulse};
  assign w_pend        = r_pend | w_pulses;
  assign w_unused_cpsr = ^cpsr_in[5:0];

  exception_prio u_prio (
    .i_pend    (w_pend),
    .i_fiq_req (fiq_req),
    .i_irq_req (irq_req),
    .i_cpsr_i  (cpsr_in[7]),
    .i_cpsr_f  (cpsr_in[6]),
    .o_valid   (w_valid),
    .o_exc     (w_exc),
    .o_mode    (w_mode),
    .o_vec_off (w_vec_off),
    .o_lr_off  (w_lr_off),
    .o_set_f   (w_set_f)
  );

  // A flush discards the old stream's pending bits, but a pulse in that same cycle survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_pend <= '0;
    else          r_pend <= (r_flush ? 4'b0 : r_pend) | w_pulses;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_wr_en     <= 1'b0;
      r_wr_sel    <= SEL_SPSR;
      r_wr_mode   <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_flush     <= 1'b0;
      r_exc_taken <= '0;
      r_new_mode  <= '0;
      r_lr        <= '0;
      r_new_cpsr  <= '0;
      r_pc        <= '0;
      r_code      <= '0;
    end else begin
      r_wr_en     <= 1'b0;
      r_wr_sel    <= SEL_SPSR;
      r_wr_mode   <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_flush     <= 1'b0;
      r_exc_taken <= '0;
      case (r_state)
        IDLE: begin
          if (instr_boundary && w_valid) begin
            r_state    <= SAVE_SPSR;
            r_wr_en    <= 1'b1;
            r_wr_mode  <= w_mode;
            r_wr_data  <= cpsr_in;
            r_busy     <= 1'b1;
            r_new_mode <= w_mode;
            r_lr       <= cur_addr + w_lr_off;
            r_new_cpsr <= entry_cpsr(cpsr_in[31:8], cpsr_in[6], w_set_f, w_mode);
            r_pc       <= VECTOR_BASE + w_vec_off;
            r_code     <= w_exc;
          end
        end
        SAVE_SPSR: begin
          r_state   <= WRITE_LR;
          r_wr_en   <= 1'b1;
          r_wr_sel  <= SEL_R14;
          r_wr_mode <= r_new_mode;
          r_wr_data <= r_lr;
          r_busy    <= 1'b1;
        end
        WRITE_LR: begin
          r_state   <= WRITE_CPSR;
          r_wr_en   <= 1'b1;
          r_wr_sel  <= SEL_CPSR;
          r_wr_mode <= r_new_mode;
          r_wr_data <= r_new_cpsr;
          r_busy    <= 1'b1;
        end
        WRITE_CPSR: begin
          r_state     <= WRITE_PC;
          r_wr_en     <= 1'b1;
          r_wr_sel    <= SEL_PC;
          r_wr_mode   <= r_new_mode;
          r_wr_data   <= r_pc;
          r_busy      <= 1'b1;
          r_flush     <= 1'b1;
          r_exc_taken <= r_code;
        end
        WRITE_PC: r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_sel    = r_wr_sel;
  assign wr_mode   = r_wr_mode;
  assign wr_data   = r_wr_data;
  assign busy      = r_busy;
  assign flush     = r_flush;
  assign exc_taken = r_exc_taken;

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench for exception_sequencer: one task per scenario, with
// hand-computed register-bank write sequences compared cycle by cycle.
module tb_exception_sequencer;

  logic        clk;
  logic        resetN;
  logic        instrBoundary;
  logic [31:0] curAddr;
  logic [31:0] cpsrIn;
  logic        fiqReq;
  logic        irqReq;
  logic        dabtPulse;
  logic        pabtPulse;
  logic        undefPulse;
  logic        swiPulse;

  logic        wrEn,     hiWrEn;
  logic [1:0]  wrSel,    hiWrSel;
  logic [4:0]  wrMode,   hiWrMode;
  logic [31:0] wrData,   hiWrData;
  logic        busy,     hiBusy;
  logic        flush,    hiFlush;
  logic [2:0]  excTaken, hiExcTaken;

  logic [44:0] obs;
  logic [44:0] hiObs;

  int testsRun    = 0;
  int testsFailed = 0;

  assign obs   = {wrEn, wrSel, wrMode, wrData, busy, flush, excTaken};
  assign hiObs = {hiWrEn, hiWrSel, hiWrMode, hiWrData, hiBusy, hiFlush, hiExcTaken};

  exception_sequencer dut (
    .clk(clk), .reset_n(resetN), .instr_boundary(instrBoundary),
    .cur_addr(curAddr), .cpsr_in(cpsrIn), .fiq_req(fiqReq), .irq_req(irqReq),
    .dabt_pulse(dabtPulse), .pabt_pulse(pabtPulse), .undef_pulse(undefPulse),
    .swi_pulse(swiPulse), .wr_en(wrEn), .wr_sel(wrSel), .wr_mode(wrMode),
    .wr_data(wrData), .busy(busy), .flush(flush), .exc_taken(excTaken)
  );

  exception_sequencer #(.VECTOR_BASE(32'hFFFF_0000)) dutHi (
    .clk(clk), .reset_n(resetN), .instr_boundary(instrBoundary),
    .cur_addr(curAddr), .cpsr_in(cpsrIn), .fiq_req(fiqReq), .irq_req(irqReq),
    .dabt_pulse(dabtPulse), .pabt_pulse(pabtPulse), .undef_pulse(undefPulse),
    .swi_pulse(swiPulse), .wr_en(hiWrEn), .wr_sel(hiWrSel), .wr_mode(hiWrMode),
    .wr_data(hiWrData), .busy(hiBusy), .flush(hiFlush), .exc_taken(hiExcTaken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected observation for one write cycle; flush rides only on the PC write.
  function automatic logic [44:0] expW(input logic [1:0] sel, input logic [4:0] mode,
                                       input logic [31:0] data, input logic [2:0] code);
    return {1'b1, sel, mode, data, 1'b1, (sel == 2'd3), code};
  endfunction

  task automatic test_reset();
    resetN = 1'b0; instrBoundary = 1'b0; curAddr = '0; cpsrIn = '0;
    fiqReq = 1'b0; irqReq = 1'b0; dabtPulse = 1'b0; pabtPulse = 1'b0;
    undefPulse = 1'b0; swiPulse = 1'b0;
    repeat (2) tick();
    testsRun++;
    if (obs !== 45'd0 || hiObs !== 45'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: got %h / %h expected 0", obs, hiObs);
    end
    resetN = 1'b1;
    tick();
    testsRun++;
    if (obs !== 45'd0) begin
      testsFailed++;
      $display("[TB] FAIL after_reset_idle: got %h expected 0", obs);
    end
  endtask

  task automatic test_irq();
    logic [44:0] seq [5];
    seq[0] = expW(2'd0, 5'b10010, 32'h0000_0010, 3'd0);
    seq[1] = expW(2'd1, 5'b10010, 32'h0000_0104, 3'd0);
    seq[2] = expW(2'd2, 5'b10010, 32'h0000_0092, 3'd0);
    seq[3] = expW(2'd3, 5'b10010, 32'h0000_0018, 3'd3);
    seq[4] = 45'd0;
    instrBoundary = 1'b1; irqReq = 1'b1; cpsrIn = 32'h10; curAddr = 32'h100;
    tick();
    instrBoundary = 1'b0; irqReq = 1'b0;
    for (int i = 0; i < 5; i++) begin
      testsRun++;
      if (obs !== seq[i]) begin
        testsFailed++;
        $display("[TB] FAIL irq_entry step %0d: got %h expected %h", i, obs, seq[i]);
      end
      tick();
    end
  endtask

  task automatic test_dabt_then_fiq();
    logic [44:0] seq [10];
    seq[0] = expW(2'd0, 5'b10111, 32'h0000_0010, 3'd0);
    seq[1] = expW(2'd1, 5'b10111, 32'h0000_0208, 3'd0);
    seq[2] = expW(2'd2, 5'b10111, 32'h0000_0097, 3'd0);
    seq[3] = expW(2'd3, 5'b10111, 32'h0000_0010, 3'd1);
    seq[4] = 45'd0;
    seq[5] = expW(2'd0, 5'b10001, 32'h0000_0097, 3'd0);
    seq[6] = expW(2'd1, 5'b10001, 32'h0000_0304, 3'd0);
    seq[7] = expW(2'd2, 5'b10001, 32'h0000_00D1, 3'd0);
    seq[8] = expW(2'd3, 5'b10001, 32'h0000_001C, 3'd2);
    seq[9] = 45'd0;
    instrBoundary = 1'b1; dabtPulse = 1'b1; fiqReq = 1'b1; cpsrIn = 32'h10; curAddr = 32'h200;
    tick();
    instrBoundary = 1'b0; dabtPulse = 1'b0;
    for (int i = 0; i < 10; i++) begin
      testsRun++;
      if (obs !== seq[i]) begin
        testsFailed++;
        $display("[TB] FAIL dabt_fiq step %0d: got %h expected %h", i, obs, seq[i]);
      end
      if (i == 4) begin
        instrBoundary = 1'b1; cpsrIn = 32'h97; curAddr = 32'h300;
      end
      tick();
      if (i == 4) begin
        instrBoundary = 1'b0; fiqReq = 1'b0;
      end
    end
  endtask

  task automatic test_masked_irq_then_swi();
    logic [44:0] seq [5];
    seq[0] = expW(2'd0, 5'b10011, 32'h0000_0090, 3'd0);
    seq[1] = expW(2'd1, 5'b10011, 32'h0000_0404, 3'd0);
    seq[2] = expW(2'd2, 5'b10011, 32'h0000_0093, 3'd0);
    seq[3] = expW(2'd3, 5'b10011, 32'h0000_0008, 3'd6);
    seq[4] = 45'd0;
    instrBoundary = 1'b1; irqReq = 1'b1; cpsrIn = 32'h90; curAddr = 32'h400;
    for (int i = 0; i < 3; i++) begin
      tick();
      testsRun++;
      if (obs !== 45'd0) begin
        testsFailed++;
        $display("[TB] FAIL masked_irq cycle %0d: got %h expected 0", i, obs);
      end
    end
    swiPulse = 1'b1;
    tick();
    swiPulse = 1'b0; instrBoundary = 1'b0; irqReq = 1'b0;
    for (int i = 0; i < 5; i++) begin
      testsRun++;
      if (obs !== seq[i]) begin
        testsFailed++;
        $display("[TB] FAIL swi_entry step %0d: got %h expected %h", i, obs, seq[i]);
      end
      tick();
    end
  endtask

  task automatic test_high_vectors();
    logic [44:0] hiSeq [5];
    logic [44:0] loSeq [5];
    hiSeq[0] = expW(2'd0, 5'b11011, 32'h0000_0010, 3'd0);
    hiSeq[1] = expW(2'd1, 5'b11011, 32'h0000_0000, 3'd0);
    hiSeq[2] = expW(2'd2, 5'b11011, 32'h0000_009B, 3'd0);
    hiSeq[3] = expW(2'd3, 5'b11011, 32'hFFFF_0004, 3'd5);
    hiSeq[4] = 45'd0;
    loSeq = hiSeq;
    loSeq[3] = expW(2'd3, 5'b11011, 32'h0000_0004, 3'd5);
    instrBoundary = 1'b1; undefPulse = 1'b1; cpsrIn = 32'h10; curAddr = 32'hFFFF_FFFC;
    tick();
    instrBoundary = 1'b0; undefPulse = 1'b0;
    for (int i = 0; i < 5; i++) begin
      testsRun++;
      if (hiObs !== hiSeq[i]) begin
        testsFailed++;
        $display("[TB] FAIL undef_hivec step %0d: got %h expected %h", i, hiObs, hiSeq[i]);
      end
      testsRun++;
      if (obs !== loSeq[i]) begin
        testsFailed++;
        $display("[TB] FAIL undef_lovec step %0d: got %h expected %h", i, obs, loSeq[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_sequence();
    instrBoundary = 1'b1; irqReq = 1'b1; pabtPulse = 1'b1; cpsrIn = 32'h10; curAddr = 32'h500;
    tick();
    instrBoundary = 1'b0; irqReq = 1'b0; pabtPulse = 1'b0;
    tick();
    testsRun++;
    if (obs !== expW(2'd1, 5'b10010, 32'h0000_0504, 3'd0)) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_lr: got %h expected %h", obs, expW(2'd1, 5'b10010, 32'h504, 3'd0));
    end
    resetN = 1'b0;
    #1;
    testsRun++;
    if (obs !== 45'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_immediate: got %h expected 0", obs);
    end
    tick();
    resetN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) instrBoundary = 1'b1;
      tick();
      instrBoundary = 1'b0;
      testsRun++;
      if (obs !== 45'd0) begin
        testsFailed++;
        $display("[TB] FAIL reset_mid_after cycle %0d: got %h expected 0", i, obs);
      end
    end
  endtask

  task automatic test_pending_during_busy();
    logic [44:0] seq [5];
    seq[0] = expW(2'd0, 5'b10111, 32'h0000_0010, 3'd0);
    seq[1] = expW(2'd1, 5'b10111, 32'h0000_0704, 3'd0);
    seq[2] = expW(2'd2, 5'b10111, 32'h0000_0097, 3'd0);
    seq[3] = expW(2'd3, 5'b10111, 32'h0000_000C, 3'd4);
    seq[4] = 45'd0;
    // Pulse before the flush cycle: discarded by the flush.
    instrBoundary = 1'b1; irqReq = 1'b1; cpsrIn = 32'h10; curAddr = 32'h600;
    tick();
    instrBoundary = 1'b0; irqReq = 1'b0;
    testsRun++;
    if (obs !== expW(2'd0, 5'b10010, 32'h10, 3'd0)) begin
      testsFailed++;
      $display("[TB] FAIL early_pabt_spsr: got %h expected %h", obs, expW(2'd0, 5'b10010, 32'h10, 3'd0));
    end
    tick();
    pabtPulse = 1'b1;
    tick();
    pabtPulse = 1'b0;
    tick();
    testsRun++;
    if (obs !== expW(2'd3, 5'b10010, 32'h18, 3'd3)) begin
      testsFailed++;
      $display("[TB] FAIL early_pabt_flush: got %h expected %h", obs, expW(2'd3, 5'b10010, 32'h18, 3'd3));
    end
    tick();
    instrBoundary = 1'b1;
    tick();
    instrBoundary = 1'b0;
    testsRun++;
    if (obs !== 45'd0) begin
      testsFailed++;
      $display("[TB] FAIL early_pabt_discarded: got %h expected 0", obs);
    end
    // Pulse in the flush cycle: retained and taken at the next boundary.
    instrBoundary = 1'b1; irqReq = 1'b1; cpsrIn = 32'h10; curAddr = 32'h680;
    tick();
    instrBoundary = 1'b0; irqReq = 1'b0;
    repeat (3) tick();
    testsRun++;
    if (obs !== expW(2'd3, 5'b10010, 32'h18, 3'd3)) begin
      testsFailed++;
      $display("[TB] FAIL late_pabt_flush: got %h expected %h", obs, expW(2'd3, 5'b10010, 32'h18, 3'd3));
    end
    pabtPulse = 1'b1;
    tick();
    pabtPulse = 1'b0; instrBoundary = 1'b1; curAddr = 32'h700;
    tick();
    instrBoundary = 1'b0;
    for (int i = 0; i < 5; i++) begin
      testsRun++;
      if (obs !== seq[i]) begin
        testsFailed++;
        $display("[TB] FAIL late_pabt_entry step %0d: got %h expected %h", i, obs, seq[i]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_irq();
    test_dabt_then_fiq();
    test_masked_irq_then_swi();
    test_high_vectors();
    test_reset_mid_sequence();
    test_pending_during_busy();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
